// File: rtl/muldiv_if.sv
// Operand/result bundle between the pipeline and muldiv_unit.
// The abort line exists only when MULDIV_ABORT_EN is defined.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] ALUin1;
  logic [WIDTH-1:0] ALUin2;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
`ifdef MULDIV_ABORT_EN
  logic             abort;
`endif

  modport master (
`ifdef MULDIV_ABORT_EN
    output abort,
`endif
    output start, op, ALUin1, ALUin2,
    input  hi, lo, busy, done
  );

  modport slave (
`ifdef MULDIV_ABORT_EN
    input  abort,
`endif
    input  start, op, ALUin1, ALUin2,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Optional MULDIV_ABORT_EN adds an abort input that cancels a running operation.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [2:0]      OP_MTHI  = 3'b100;
  localparam logic [2:0]      OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10} state_t;

  function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic signed_op);
    if (signed_op && v[WIDTH-1]) begin
      return neg_val(v);
    end else begin
      return v;
    end
  endfunction

  state_t             state_r, state_s;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opd_r;
  logic [CW-1:0]      cnt_r;
  logic               is_div_r, neg_lo_r, neg_hi_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r;

  logic               abort_s, accept_s, signed_s, div0_s, sign_diff_s;
  logic [WIDTH-1:0]   a_abs_s, b_abs_s;
  logic [WIDTH:0]     mul_sum_s, div_t_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic               div_ge_s;
  logic [2*WIDTH-1:0] step_s, prod_fix_s;
  logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

`ifdef MULDIV_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  // op[2]==0 selects the four mul/div opcodes; op[0]==0 marks the signed ones
  assign accept_s    = (state_r == IDLE) && bus.start && (bus.op[2] == 1'b0);
  assign signed_s    = ~bus.op[0];
  assign div0_s      = (bus.ALUin2 == {WIDTH{1'b0}});
  assign sign_diff_s = signed_s & (bus.ALUin1[WIDTH-1] ^ bus.ALUin2[WIDTH-1]);
  assign a_abs_s     = abs_val(bus.ALUin1, signed_s);
  assign b_abs_s     = abs_val(bus.ALUin2, signed_s);

  // One shift-add (multiply) or restoring shift-subtract (divide) step
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                 (acc_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
    div_t_s    = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_ge_s   = (div_t_s >= {1'b0, opd_r});
    div_diff_s = div_t_s[WIDTH-1:0] - opd_r;
    if (is_div_r) begin
      step_s = {(div_ge_s ? div_diff_s : div_t_s[WIDTH-1:0]), acc_r[WIDTH-2:0], div_ge_s};
    end else begin
      step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX; divide-by-zero flags were cleared at start
  always_comb begin
    prod_fix_s = neg_lo_r ? ((~acc_r) + (2*WIDTH)'(1)) : acc_r;
    if (is_div_r) begin
      fix_hi_s = neg_hi_r ? neg_val(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
      fix_lo_s = neg_lo_r ? neg_val(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    end else begin
      fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = CALC;
        else          state_s = IDLE;
      end
      CALC: begin
        if (abort_s)                  state_s = IDLE;
        else if (cnt_r == {CW{1'b0}}) state_s = FIX;
        else                          state_s = CALC;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      opd_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      is_div_r <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            busy_r   <= 1'b1;
            cnt_r    <= CNT_LAST;
            is_div_r <= bus.op[1];
            if (bus.op[1]) begin
              // Divide by zero keeps the raw dividend so it falls out as the remainder
              acc_r    <= {{WIDTH{1'b0}}, (div0_s ? bus.ALUin1 : a_abs_s)};
              opd_r    <= b_abs_s;
              neg_lo_r <= sign_diff_s & ~div0_s;
              neg_hi_r <= signed_s & bus.ALUin1[WIDTH-1] & ~div0_s;
            end else begin
              acc_r    <= {{WIDTH{1'b0}}, b_abs_s};
              opd_r    <= a_abs_s;
              neg_lo_r <= sign_diff_s;
              neg_hi_r <= 1'b0;
            end
          end else if (bus.start && (bus.op == OP_MTHI)) begin
            hi_r <= bus.ALUin1;
          end else if (bus.start && (bus.op == OP_MTLO)) begin
            lo_r <= bus.ALUin1;
          end
        end
        CALC: begin
          if (abort_s) begin
            busy_r <= 1'b0;
          end else begin
            acc_r <= step_s;
            if (cnt_r != {CW{1'b0}}) cnt_r <= cnt_r - CW'(1);
          end
        end
        FIX: begin
          busy_r <= 1'b0;
          if (!abort_s) begin
            hi_r   <= fix_hi_s;
            lo_r   <= fix_lo_s;
            done_r <= 1'b1;
          end
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule
